// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer
//   Converts an in-order stream of aligned 32-bit fetch words into one
//   instruction per decode handshake. Each instruction is either 16-bit
//   (compressed) or 32-bit, and a 32-bit instruction may straddle two fetch
//   words. The block tracks the next fetch address and the PC of the
//   instruction at the head, and a flush redirects both to a
//   halfword-aligned target.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   flush, flush_pc   redirect; discards all buffered halfwords
//   fetch_addr        word-aligned address of the next word to be accepted
//   word_valid/ready  fetch word handshake; word_data[15:0] is the lower address
//   word_fault        access fault attached to the fetch word
//   instr_valid/ready instruction handshake toward decode
//   instr             instruction; a compressed one is zero-extended
//   instr_pc          PC of instr
//   instr_compressed  instr is 16-bit
//   instr_fault       instr comes from a faulted word
module fetch_align_buffer #(
  parameter int unsigned HBUF_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] fetch_addr,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  input  logic        word_fault,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed,
  output logic        instr_fault
);

  localparam int unsigned PTR_W = $clog2(HBUF_DEPTH);
  localparam logic [PTR_W:0] PUSH_LIMIT = (PTR_W+1)'(HBUF_DEPTH - 2);
  localparam logic [PTR_W:0] CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO    = (PTR_W+1)'(2);

  logic [15:0]      hbuf_data  [HBUF_DEPTH];
  logic             hbuf_fault [HBUF_DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [PTR_W:0]   count_q;
  logic [31:0]      head_pc_q;
  logic [31:0]      fetch_addr_q;
  logic             skip_lo_q;

  logic             push, pop, pop_two;
  logic [PTR_W:0]   push_n, pop_n;
  logic [15:0]      hw0, hw1;
  logic             hw0_fault, hw1_fault;

  // Only the bits that form a halfword address are used from the target.
  logic             unused_flush_pc0;
  assign unused_flush_pc0 = flush_pc[0];

  always_comb begin
    head_p1   = head_q + PTR_W'(1);
    tail_p1   = tail_q + PTR_W'(1);
    hw0       = hbuf_data[head_q];
    hw1       = hbuf_data[head_p1];
    hw0_fault = hbuf_fault[head_q];
    hw1_fault = hbuf_fault[head_p1];
  end

  // Push side: judged on registered occupancy only, so a word is never
  // accepted on the strength of a pop happening in the same cycle.
  always_comb begin
    word_ready = !flush && (count_q <= PUSH_LIMIT);
    push       = word_valid && word_ready;
    push_n     = '0;
    if (push) push_n = skip_lo_q ? CNT_ONE : CNT_TWO;
  end

  // Head decode. A faulted head halfword is issued alone so the fault is
  // reported at the exact PC, regardless of what its low bits look like.
  always_comb begin
    instr_valid      = 1'b0;
    instr            = '0;
    instr_compressed = 1'b0;
    instr_fault      = 1'b0;
    pop_two          = 1'b0;
    if (!flush) begin
      if (hw0_fault) begin
        instr_valid = (count_q != '0);
        instr_fault = instr_valid;
      end else if (hw0[1:0] != 2'b11) begin
        instr_valid      = (count_q != '0);
        instr_compressed = instr_valid;
        if (instr_valid) instr = {16'h0000, hw0};
      end else begin
        instr_valid = (count_q >= CNT_TWO);
        pop_two     = 1'b1;
        if (instr_valid) begin
          instr       = {hw1, hw0};
          instr_fault = hw1_fault;
        end
      end
    end
    pop   = instr_valid && instr_ready;
    pop_n = '0;
    if (pop) pop_n = pop_two ? CNT_TWO : CNT_ONE;
  end

  assign fetch_addr = fetch_addr_q;
  assign instr_pc   = head_pc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      head_pc_q    <= RESET_PC;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      skip_lo_q    <= RESET_PC[1];
    end else if (flush) begin
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      head_pc_q    <= {flush_pc[31:1], 1'b0};
      fetch_addr_q <= {flush_pc[31:2], 2'b00};
      skip_lo_q    <= flush_pc[1];
    end else begin
      count_q <= count_q + push_n - pop_n;
      if (pop) begin
        head_q    <= pop_two ? (head_q + PTR_W'(2)) : head_p1;
        head_pc_q <= head_pc_q + (pop_two ? 32'd4 : 32'd2);
      end
      if (push) begin
        tail_q       <= skip_lo_q ? tail_p1 : (tail_q + PTR_W'(2));
        skip_lo_q    <= 1'b0;
        fetch_addr_q <= fetch_addr_q + 32'd4;
      end
    end
  end

  // Storage needs no reset: entries beyond count are never observed.
  // After a redirect into the upper half of a word only that half is kept.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      if (skip_lo_q) begin
        hbuf_data[tail_q]  <= word_data[31:16];
        hbuf_fault[tail_q] <= word_fault;
      end else begin
        hbuf_data[tail_q]   <= word_data[15:0];
        hbuf_fault[tail_q]  <= word_fault;
        hbuf_data[tail_p1]  <= word_data[31:16];
        hbuf_fault[tail_p1] <= word_fault;
      end
    end
  end

endmodule
